seq_div1024by32: RTL and testbench

//  Sequential radix-2 restoring divider. It computes Q = X / Y and R = X % Y for an
//  XW-bit dividend and a YW-bit divisor, producing one quotient bit per clock.
//  It is the inverse datapath of the combinational 1024x32 Wallace multiplier in

---
 rtl/seq_div1024by32.sv | 123 ++++++++++++
 tb/tb_seq_div1024by32.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div1024by32.sv
// Sequential radix-2 restoring divider: Q = X / Y, R = X % Y, one quotient bit per clock.
// Divide-by-zero short-circuits to Q = all ones, R = 0, dz = 1.
module seq_div1024by32 #(
    parameter int unsigned XW = 1024,
    parameter int unsigned YW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] X,
    input  logic [YW-1:0] Y,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [XW-1:0] Q,
    output logic [YW-1:0] R
);

    localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] s, s_nxt;
    logic [YW-1:0] d, d_nxt;
    logic [YW-1:0] pr, pr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [XW-1:0] q_nxt;
    logic [YW-1:0] r_nxt;
    logic          dz_nxt;
    logic          ready_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic [YW:0]   t;
    logic [YW:0]   diff;
    logic          ge;

    // Next-state, datapath step and registered-output decode.
    always_comb begin
        t         = {pr, s[XW-1]};
        diff      = t - {1'b0, d};
        ge        = (t >= {1'b0, d});
        state_nxt = state;
        s_nxt     = s;
        d_nxt     = d;
        pr_nxt    = pr;
        cnt_nxt   = cnt;
        q_nxt     = Q;
        r_nxt     = R;
        dz_nxt    = dz;

        case (state)
            IDLE: begin
                if (start) begin
                    if (Y != '0) begin
                        state_nxt = RUN;
                        d_nxt     = Y;
                        s_nxt     = X;
                        pr_nxt    = '0;
                        cnt_nxt   = CW'(XW - 1);
                        dz_nxt    = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        q_nxt     = '1;
                        r_nxt     = '0;
                        dz_nxt    = 1'b1;
                    end
                end
            end
            RUN: begin
                // Difference is < d whenever ge holds, so it always fits in YW bits.
                pr_nxt  = ge ? diff[YW-1:0] : t[YW-1:0];
                s_nxt   = {s[XW-2:0], ge};
                cnt_nxt = cnt - CW'(1);
                if (cnt == '0) begin
                    state_nxt = DONE;
                    q_nxt     = s_nxt;
                    r_nxt     = pr_nxt;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt == RUN);
        done_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            d     <= '0;
            pr    <= '0;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            d     <= d_nxt;
            pr    <= pr_nxt;
            cnt   <= cnt_nxt;
            Q     <= q_nxt;
            R     <= r_nxt;
            dz    <= dz_nxt;
            ready <= ready_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_div1024by32.sv
// Scoreboard bench for seq_div1024by32: expected results queued at issue, checked at done.
module tb_seq_div1024by32;

    localparam int unsigned XW = 1024;
    localparam int unsigned YW = 32;
    localparam int unsigned PW = XW + YW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic          ready, busy, done, dz;
    logic [XW-1:0] Q;
    logic [YW-1:0] R;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] q;
        logic [YW-1:0] r;
        logic          dz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_div1024by32 #(.XW(XW), .YW(YW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .Q     (Q),
        .R     (R)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] v;
        for (int i = 0; i < XW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [XW-1:0] x, input logic [YW-1:0] y);
        exp_t e;
        int   g = 0;
        while (!ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!ready) check("ready_wait", PW'(ready), PW'(1));
        e.x = x;
        e.y = y;
        if (y == '0) begin
            e.q = '1; e.r = '0; e.dz = 1'b1; e.lat = 0;
        end else begin
            e.q = x / XW'(y); e.r = YW'(x % XW'(y)); e.dz = 1'b0; e.lat = XW;
        end
        sb.push_back(e);
        X = x;
        Y = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        X = ~x;
        Y = y + 32'd1;
    endtask

    // Waits for done; 'already' is the number of negedges consumed since issue returned.
    task automatic finish_op(input string tag, input int already);
        exp_t          e;
        int            cyc;
        logic [PW-1:0] prod;
        cyc = 1 + already;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, PW'(cyc - 1), PW'(e.lat));
        check({tag, "_Q"}, PW'(Q), PW'(e.q));
        check({tag, "_R"}, PW'(R), PW'(e.r));
        check({tag, "_dz"}, PW'(dz), PW'(e.dz));
        if (!e.dz) begin
            prod = PW'(Q) * PW'(e.y) + PW'(R);
            check({tag, "_qy+r"}, prod, PW'(e.x));
            check({tag, "_r<y"}, PW'(R < e.y), PW'(1));
        end
        @(negedge clk);
        check({tag, "_pulse"}, PW'({done, ready}), PW'(2'b01));
    endtask

    initial begin
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        repeat (3) @(negedge clk);
        check("rst_flags", PW'({ready, busy, done, dz}), PW'(4'b1000));
        check("rst_Q", PW'(Q), PW'(0));
        check("rst_R", PW'(R), PW'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(XW'(100), 32'd7);
        finish_op("t1", 0);
        check("t1_Qc", PW'(Q), PW'(14));

        xv = '1;
        issue(xv, 32'hFFFF_FFFF);
        finish_op("t2", 0);
        check("t2_Qc", PW'(Q), PW'({32{32'h0000_0001}}));

        issue(rand_x(), 32'd0);
        finish_op("t3a", 0);
        issue(XW'(10), 32'd3);
        finish_op("t3b", 0);

        // Start pulsed mid-run must be ignored.
        xv = rand_x();
        issue(xv, 32'd1);
        repeat (10) @(negedge clk);
        X = rand_x(); Y = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy", PW'(busy), PW'(1));
        finish_op("t4", 11);
        check("t4_QeqX", PW'(Q), PW'(xv));

        issue(XW'(5), 32'd9);
        finish_op("x_lt_y", 0);
        issue(XW'(0), 32'd123);
        finish_op("x_zero", 0);

        // Abort mid-run.
        issue(rand_x(), 32'd77);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_front());
        check("t5_flags", PW'({ready, busy, done, dz}), PW'(4'b1000));
        check("t5_Q", PW'(Q), PW'(0));
        check("t5_R", PW'(R), PW'(0));
        start = 1'b1; X = XW'(50); Y = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("rst_prio", PW'({ready, busy}), PW'(2'b10));
        rst = 1'b0;
        @(negedge clk);
        issue(XW'(1000), 32'd33);
        finish_op("t5_after", 0);

        for (int i = 0; i < 40; i++) begin
            yv = $urandom >> $urandom_range(0, 31);
            if (yv == '0) yv = 32'd1;
            issue(rand_x(), yv);
            finish_op("rand", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
